// File: rtl/shift_serdes_pkg.sv
// Shared types and constants for the shift_serdes full-duplex serialiser.
// Optional parity framing is enabled by defining SHIFT_SERDES_PARITY_EN.
package shift_serdes_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_PAR   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Sized for the largest supported word (32 bits) so every BITS setting fits.
    localparam int BITS_MAX = 32;
    localparam int CNT_W    = $clog2(BITS_MAX + 1);

    localparam logic Q_IDLE = 1'b1;

endpackage

// File: rtl/shift_serdes_tick.sv
// Programmable bit-period divider: tick on the last cycle of each div+1 cycle period.
// Held at zero while clear is high so every frame starts on a fresh period.
module bit_tick_gen #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    assign tick = ena && !clear && (r_cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ena) begin
            if (clear || tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/shift_serdes.sv
// Full-duplex parallel/serial shifter with programmable bit rate and bit order.
// Define SHIFT_SERDES_PARITY_EN to append an even-parity bit period to every frame.
module shift_serdes
    import shift_serdes_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load,
    input  logic [BITS-1:0]  d,
    input  logic             lsb_first,
    input  logic [DIV_W-1:0] div,
    input  logic             sin,
    output logic             q,
    output logic             busy,
    output logic             eos,
    output logic [BITS-1:0]  rx_data,
    output logic             rx_valid,
    output logic             rx_perr
);

    state_t           r_state;
    logic [BITS-1:0]  r_tx;
    logic [BITS-1:0]  r_rx;
    logic [BITS-1:0]  r_rx_data;
    logic             r_lsb;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_bit_cnt;

    logic             w_active;
    logic             w_tick;
    logic             w_last_bit;
    logic             w_tx_bit;
    logic             w_par_bit;
    logic [BITS-1:0]  w_rx_shift;

    assign w_active   = (r_state == ST_SHIFT) || (r_state == ST_PAR);
    assign w_last_bit = (r_bit_cnt == CNT_W'(BITS - 1));
    assign w_tx_bit   = r_lsb ? r_tx[0] : r_tx[BITS-1];
    // Received bits land so that the first one ends up where it was sent from.
    assign w_rx_shift = r_lsb ? {sin, r_rx[BITS-1:1]} : {r_rx[BITS-2:0], sin};

    bit_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clear (!w_active),
        .div   (r_div),
        .tick  (w_tick)
    );

`ifdef SHIFT_SERDES_PARITY_EN
    logic r_par;
    logic r_perr;

    assign w_par_bit = r_par;
    assign rx_perr   = r_perr;
`else
    assign w_par_bit = Q_IDLE;
    assign rx_perr   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_lsb     <= 1'b0;
            r_div     <= '0;
            r_bit_cnt <= '0;
`ifdef SHIFT_SERDES_PARITY_EN
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else if (ena) begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (load) begin
                        r_state   <= ST_SHIFT;
                        r_tx      <= d;
                        r_rx      <= '0;
                        r_lsb     <= lsb_first;
                        r_div     <= div;
                        r_bit_cnt <= '0;
`ifdef SHIFT_SERDES_PARITY_EN
                        r_par     <= ^d;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_rx      <= w_rx_shift;
                        r_tx      <= r_lsb ? (r_tx >> 1) : (r_tx << 1);
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (w_last_bit) begin
`ifdef SHIFT_SERDES_PARITY_EN
                            r_state   <= ST_PAR;
`else
                            r_state   <= ST_DONE;
                            r_rx_data <= w_rx_shift;
`endif
                        end
                    end
                end
                ST_PAR: begin
`ifdef SHIFT_SERDES_PARITY_EN
                    if (w_tick) begin
                        r_state   <= ST_DONE;
                        r_rx_data <= r_rx;
                        r_perr    <= sin ^ (^r_rx);
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = w_active;
    assign eos      = (r_state == ST_DONE);
    assign rx_valid = (r_state == ST_DONE);
    assign rx_data  = r_rx_data;
    assign q        = (r_state == ST_SHIFT) ? w_tx_bit :
                      (r_state == ST_PAR)   ? w_par_bit : Q_IDLE;

endmodule

// File: tb/tb_shift_serdes.sv
// Directed bench for shift_serdes: per-cycle q/busy/eos checks plus an rx scoreboard.
module tb_shift_serdes;

    localparam int BITS  = 8;
    localparam int DIV_W = 4;
`ifdef SHIFT_SERDES_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam int FRAME = BITS + (PAR_ON ? 1 : 0);

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             load;
    logic [BITS-1:0]  d;
    logic             lsb_first;
    logic [DIV_W-1:0] div;
    logic             sin;
    logic             q;
    logic             busy;
    logic             eos;
    logic [BITS-1:0]  rx_data;
    logic             rx_valid;
    logic             rx_perr;

    logic loop_en;
    logic sin_drv;
    logic inv_par;

    int n_cmp = 0;
    int n_err = 0;

    logic [BITS-1:0] sb_data[$];
    logic            sb_perr[$];

    assign sin = loop_en ? (q ^ inv_par) : sin_drv;

    shift_serdes #(
        .BITS  (BITS),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .load      (load),
        .d         (d),
        .lsb_first (lsb_first),
        .div       (div),
        .sin       (sin),
        .q         (q),
        .busy      (busy),
        .eos       (eos),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_perr   (rx_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Received words are scored when the DUT strobes rx_valid.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            check("rx_valid pending", 32'(sb_data.size() != 0), 32'd1);
            if (sb_data.size() != 0) begin
                logic [BITS-1:0] ed;
                logic            ep;
                ed = sb_data.pop_front();
                ep = sb_perr.pop_front();
                check("rx_data", 32'(rx_data), 32'(ed));
                check("rx_perr", 32'(rx_perr), 32'(ep));
            end
        end
    end

    // Drives load in the current cycle and checks every cycle through the eos cycle.
    task automatic frame(input string tag, input logic [BITS-1:0] fd, input logic [DIV_W-1:0] fdiv,
                         input logic flsb, input logic [BITS-1:0] exp_rx, input logic exp_perr,
                         input int ign_at, input int gap_at, input logic inv);
        int   len;
        int   k;
        logic qe;
        len = FRAME * (int'(fdiv) + 1) + 1;
        load = 1'b1; d = fd; div = fdiv; lsb_first = flsb;
        sb_data.push_back(exp_rx);
        sb_perr.push_back(exp_perr);
        for (int c = 1; c <= len; c++) begin
            step();
            load = 1'b0; d = ~fd; div = ~fdiv; lsb_first = ~flsb;
            k = (c - 1) / (int'(fdiv) + 1);
            if (c == len)       qe = 1'b1;
            else if (k >= BITS) qe = ^fd;
            else                qe = flsb ? fd[k] : fd[BITS-1-k];
            inv_par = inv && (k == BITS) && (c != len);
            check({tag, " q"},        32'(q),        32'(qe));
            check({tag, " busy"},     32'(busy),     32'(c != len));
            check({tag, " eos"},      32'(eos),      32'(c == len));
            check({tag, " rx_valid"}, 32'(rx_valid), 32'(c == len));
            if (c == ign_at) begin
                load = 1'b1;
                d    = '0;
            end
            if (c == gap_at) begin
                ena = 1'b0;
                for (int g = 0; g < 5; g++) begin
                    step();
                    check({tag, " gap q"},   32'(q),   32'(qe));
                    check({tag, " gap eos"}, 32'(eos), 32'd0);
                end
                ena = 1'b1;
            end
        end
        $display("frame %s d=%0h div=%0d lsb=%0d done (%0d cycles)", tag, fd, fdiv, flsb, len);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; load = 1'b0; d = '0; lsb_first = 1'b0; div = '0;
        loop_en = 1'b1; sin_drv = 1'b1; inv_par = 1'b0;
        repeat (3) step();
        check("rst q",        32'(q),        32'd1);
        check("rst busy",     32'(busy),     32'd0);
        check("rst eos",      32'(eos),      32'd0);
        check("rst rx_valid", 32'(rx_valid), 32'd0);
        check("rst rx_data",  32'(rx_data),  32'd0);
        check("rst rx_perr",  32'(rx_perr),  32'd0);
        rst_n = 1'b1;
        step();

        // MSB-first loopback at full rate
        frame("t1", 8'hA5, 4'd0, 1'b0, 8'hA5, 1'b0, -1, -1, 1'b0);
        step();
        check("t1 idle eos", 32'(eos), 32'd0);

        // LSB-first, 4 cycles per bit, sin held high
        loop_en = 1'b0; sin_drv = 1'b1;
        frame("t2", 8'h01, 4'd3, 1'b1, 8'hFF, PAR_ON, -1, -1, 1'b0);
        loop_en = 1'b1;
        step();

        // Load while busy is ignored; load in the eos cycle chains the next frame
        frame("t3", 8'h3C, 4'd0, 1'b0, 8'h3C, 1'b0, 4, -1, 1'b0);
        frame("t3b", 8'hC3, 4'd1, 1'b1, 8'hC3, 1'b0, -1, -1, 1'b0);
        step();

        // Enable dropped for 5 cycles mid-frame
        frame("t4", 8'h96, 4'd0, 1'b1, 8'h96, 1'b0, -1, 3, 1'b0);
        step();

        // Asynchronous reset mid-frame discards the frame
        load = 1'b1; d = 8'h5A; div = 4'd0; lsb_first = 1'b0;
        step();
        load = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t5 rst q",        32'(q),        32'd1);
        check("t5 rst busy",     32'(busy),     32'd0);
        check("t5 rst eos",      32'(eos),      32'd0);
        check("t5 rst rx_valid", 32'(rx_valid), 32'd0);
        check("t5 rst rx_data",  32'(rx_data),  32'd0);
        check("t5 rst rx_perr",  32'(rx_perr),  32'd0);
        $display("reset pulse mid-frame applied");
        step();
        rst_n = 1'b1;
        step();
        frame("t5", 8'h5A, 4'd0, 1'b0, 8'h5A, 1'b0, -1, -1, 1'b0);
        step();

        // Parity framing: clean loopback, then parity bit inverted on the line
        frame("t6", 8'h07, 4'd0, 1'b0, 8'h07, 1'b0, -1, -1, 1'b0);
        step();
        frame("t6inv", 8'h07, 4'd0, 1'b0, 8'h07, PAR_ON, -1, -1, 1'b1);
        inv_par = 1'b0;
        step();

        check("scoreboard drained", 32'(sb_data.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
